// File: rtl/axi_line_port_if.sv
// axi_line_port_if: AXI4 master bundle (32-bit data, 4-bit id, 8-bit len) between the line port and the crossbar
interface axi_line_port_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arcache, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arcache, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_line_port.sv
// axi_line_port: CPU request port to AXI4 master with single-beat and cache-line burst transfers
module axi_line_port #(
    parameter int LINE_WORDS = 8,
    parameter int AXI_ID     = 0,
    parameter int WRITE_EN   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wr_i,
    input  logic        req_line_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [3:0]  req_wstrb_i,
    input  logic        cpu_wvalid_i,
    input  logic [31:0] cpu_wdata_i,
    output logic        cpu_wready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_last_o,
    output logic        wr_done_o,
    output logic        rsp_err_o,
    axi_line_port_if.master m
);
    localparam int          LB        = $clog2(LINE_WORDS) + 2;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << LB) - 32'd1);
    localparam logic [3:0]  ID        = 4'(AXI_ID);
    localparam bit          WE        = WRITE_EN != 0;

    typedef enum logic [2:0] {IDLE, AR, R, AWW, B} state_t;

    state_t      state_q;
    logic [31:0] addr_q, addr_d, paddr;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  cache_q, cache_d, wstrb_q, wstrb_d, cnt_q;
    logic        arvalid_q, awvalid_q, rready_q, bready_q, wr_done_q, err_q, aw_done_q, w_done_q;
    logic        accept, r_beat, w_beat, aw_beat, aw_fin, w_fin;

    // Translate kseg0/kseg1 and pick burst attributes for the capture register
    always_comb begin
        cache_d = (req_addr_i[31:29] == 3'b101) ? 4'b0000 : 4'b1111;
        paddr   = (req_addr_i[31:29] == 3'b100) ? {1'b0, req_addr_i[30:0]} :
                  (req_addr_i[31:29] == 3'b101) ? {3'b000, req_addr_i[28:0]} : req_addr_i;
        addr_d  = req_line_i ? (paddr & LINE_MASK) : paddr;
        len_d   = req_line_i ? 8'(LINE_WORDS - 1) : 8'd0;
        size_d  = req_line_i ? 3'd2 : {1'b0, req_size_i};
        wstrb_d = req_line_i ? 4'hF : req_wstrb_i;
    end

    assign req_ready_o  = (state_q == IDLE) && !reset && (WE || !req_wr_i);
    assign accept       = req_valid_i && req_ready_o;
    assign r_beat       = (state_q == R) && m.rvalid && (m.rid == ID);
    assign rsp_valid_o  = r_beat;
    assign rsp_data_o   = m.rdata;
    assign rsp_last_o   = r_beat && m.rlast;
    assign rsp_err_o    = err_q || (r_beat && (m.rresp != 2'b00));
    assign wr_done_o    = wr_done_q;

    assign m.arid    = ID;
    assign m.araddr  = addr_q;
    assign m.arlen   = len_q;
    assign m.arsize  = size_q;
    assign m.arburst = 2'b01;
    assign m.arcache = cache_q;
    assign m.arvalid = arvalid_q;
    assign m.rready  = rready_q;
    assign m.awid    = ID;
    assign m.awaddr  = addr_q;
    assign m.awlen   = len_q;
    assign m.awsize  = size_q;
    assign m.awburst = 2'b01;
    assign m.awcache = cache_q;
    assign m.awvalid = WE && awvalid_q;
    assign m.wdata   = cpu_wdata_i;
    assign m.wstrb   = wstrb_q;
    assign m.wlast   = cnt_q == len_q[3:0];
    assign m.wvalid  = WE && (state_q == AWW) && cpu_wvalid_i && !w_done_q;
    assign m.bready  = bready_q;

    assign w_beat       = m.wvalid && m.wready;
    assign aw_beat      = m.awvalid && m.awready;
    assign cpu_wready_o = w_beat;
    assign aw_fin       = aw_done_q || aw_beat;
    assign w_fin        = w_done_q || (w_beat && m.wlast);

    // Transaction sequencer; aw and w complete independently before the response phase
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            wr_done_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    addr_q    <= addr_d;
                    len_q     <= len_d;
                    size_q    <= size_d;
                    cache_q   <= cache_d;
                    wstrb_q   <= wstrb_d;
                    err_q     <= 1'b0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    cnt_q     <= 4'd0;
                    state_q   <= req_wr_i ? AWW : AR;
                    awvalid_q <= req_wr_i;
                    arvalid_q <= !req_wr_i;
                end
                AR: if (m.arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= R;
                end
                R: begin
                    if (r_beat && m.rresp != 2'b00) err_q <= 1'b1;
                    if (r_beat && m.rlast) begin
                        rready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                AWW: begin
                    if (aw_beat) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_beat) cnt_q <= cnt_q + 4'd1;
                    if (w_beat && m.wlast) w_done_q <= 1'b1;
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= B;
                    end
                end
                B: if (m.bvalid) begin
                    bready_q  <= 1'b0;
                    wr_done_q <= 1'b1;
                    if (m.bresp != 2'b00) err_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_line_port.md
Name: axi_line_port

Overview:
- Parametrised successor to the single-beat CPU-to-AXI bridge: one CPU request port (instruction or data side) to one AXI4 master.
- Supports single-beat uncached accesses and full cache-line INCR bursts for refill/writeback.
- Registers the request at acceptance, so the CPU need not hold the address.
- Performs fixed kseg0/kseg1 address mapping and cache attribute selection; sits between L1 cache controller and AXI crossbar.

Parameters:
- LINE_WORDS, 8, beats per line burst; power of two, 2..16.
- AXI_ID, 0, constant value driven on arid/awid.
- WRITE_EN, 1, 0 disables the write path: aw/w valids tied low, write requests never accepted.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  CPU request valid
- req_ready  out  1  request accepted this cycle
- req_wr  in  1  1=write, 0=read
- req_line  in  1  1=line burst, 0=single beat
- req_size  in  2  single-beat size (0=byte,1=half,2=word)
- req_addr  in  32  virtual address
- req_wstrb  in  4  single-beat byte strobes
- cpu_wvalid  in  1  write beat valid
- cpu_wdata  in  32  write beat data
- cpu_wready  out  1  write beat consumed
- rsp_valid  out  1  read beat valid (no backpressure)
- rsp_data  out  32  read beat data
- rsp_last  out  1  final read beat
- wr_done  out  1  write-complete pulse
- rsp_err  out  1  sticky per-transaction error, valid with rsp_last or wr_done
- m_ar*/m_r*/m_aw*/m_w*/m_b*  AXI4 master, 32-bit data, 4-bit id, 8-bit len

Behaviour:
- Reset: state IDLE; req_ready=1 only if not reset; all AXI valids, rsp_valid, rsp_last, wr_done, rsp_err, cpu_wready = 0. Reset mid-transaction aborts to IDLE immediately; only legal with a global AXI reset.
- Address map on req_addr[31:29]:
  - 100 (kseg0): paddr={1'b0,addr[30:0]}, cache=4'b1111.
  - 101 (kseg1): paddr={3'b000,addr[28:0]}, cache=4'b0000.
  - Otherwise: paddr=addr, cache=4'b1111.
- Line request: addr[log2(LINE_WORDS)+1:0] zeroed, len=LINE_WORDS-1, size=2, burst=INCR, wstrb=4'hF.
- Single request: addr unaligned-as-given, len=0, size={1'b0,req_size}, wstrb=latched req_wstrb.
- States and transitions:
  - IDLE: req_ready=1; handshake latches request; go to AR (read) or AWW (write, only when WRITE_EN=1).
  - AR: m_arvalid=1 from the cycle after acceptance; on arready go to R.
  - R: m_rready=1; each r beat -> rsp_valid=1 same cycle, combinational from rvalid, with rsp_data=rdata. rsp_last=1 on rlast. On rlast go to IDLE; next request can be accepted the following cycle.
  - AWW: awvalid and the w channel run independently, each with a done flag (aw may precede or follow w beats).
    - m_wvalid = cpu_wvalid & ~w_done; cpu_wready = m_wready & m_wvalid.
    - 4-bit beat counter; m_wlast=1 when count==len.
    - When both aw and w are done, go to B.
  - B: m_bready=1; on bvalid pulse wr_done for 1 cycle, go to IDLE.
- rsp_err: cleared at acceptance; set if any rresp or bresp != 2'b00.
- Valid stability: ar/aw/w valid and payload hold until ready; no deassert without handshake.
- Read beats arriving after rlast, or with wrong rid: ignored (not forwarded).
- Minimum latencies: single read, req to rsp_last = 2 cycles with zero-wait slave; single write, req to wr_done = 3 cycles.

Test Plan:
- Single read kseg1 0xBFC00004, size 2 -> araddr=0x1FC00004, arcache=0, arlen=0, one rsp beat with rsp_last=1.
- Line read kseg0 0x80001234, LINE_WORDS=8 -> araddr=0x00001220, arlen=7, arcache=4'hF; 8 rsp beats in order, rsp_last only on 8th; req_ready low until after last beat.
- Line write 0x80000040 with awready delayed 5 cycles after all 8 w beats -> wlast on 8th beat only, wstrb=F each beat, single wr_done after bvalid.
- Single byte write kseg1 0xA0000003, wstrb=4'b1000, wready stalled 3 cycles -> wvalid and wdata held stable, awsize=0, wr_done once.
- Read with rresp=2'b10 on beat 3 of 8 -> rsp_err=1 at rsp_last; next transaction starts with rsp_err=0.
- Reset asserted during R phase beat 4 -> all valids 0 the next cycle, req_ready=1 after reset deasserts; WRITE_EN=0 build: write request never accepted, awvalid stays 0.
